state_frame_regfile: RTL
========================

Name: state_frame_regfile

Overview:
- Parametrised ROWS x COLS word-frame register file for cipher-state datapaths (default 4x4 of 32-bit words).
- Frames are loaded column by column into a shadow bank, then committed as one frame into an output register.
- The commit can optionally apply a per-row rotation (ShiftRows-style).
- The output side is a valid/ready stage, so a new frame can be loaded while the previous one is still held for the consumer.

Parameters:
- WORD_W, 32, bits per word
- ROWS, 4, rows per frame (>=1)
- COLS, 4, columns per frame (>=2)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  load strobe for the shadow bank
- wr_col_mask  in  COLS  one bit per column to load when wr_en=1
- frame_in  in  ROWS*COLS*WORD_W  flattened input frame; word (r,c) at bits [(r*COLS+c)*WORD_W +: WORD_W]
- commit  in  1  request to transfer the shadow bank to the output
- rot_en  in  1  sampled on an accepted commit; 1 = rotate rows
- commit_ready  out  1  commit will be accepted this cycle
- frame_complete  out  1  every column has been loaded since the last commit
- frame_out  out  ROWS*COLS*WORD_W  registered output frame, same flattening as frame_in
- out_valid  out  1  frame_out holds an unconsumed frame
- out_ready  in  1  consumer accepts frame_out

Behaviour:
- All state updates on rising clk.
- Reset (rst=1) clears: shadow bank to 0, col_loaded to 0, frame_out to 0, out_valid to 0.
  - rst has priority over every other input.
  - rst asserted mid-load drops the partial frame.
  - rst asserted while out_valid=1 drops the held frame without a handshake.
- Load: when wr_en=1, for each c with wr_col_mask[c]=1:
  - shadow(r,c) <= frame_in(r,c) for all r;
  - col_loaded[c] <= 1.
  - Unmasked columns keep their values.
  - wr_en=1 with a zero mask is a no-op.
- frame_complete = &col_loaded (combinational).
- commit_ready = frame_complete && (!out_valid || out_ready) (combinational).
- Accepted commit = commit && commit_ready. Effects:
  - frame_out(r,c) <= shadow(r,(c+r) mod COLS) if rot_en=1, else shadow(r,c);
  - out_valid <= 1;
  - col_loaded <= 0. Shadow data is retained, so a partial reload plus the old columns can be recommitted after the remaining columns are rewritten.
- A commit that is not accepted is ignored, not queued. The requester must hold commit high until commit_ready=1.
- Load and accepted commit in the same cycle:
  - the committed frame uses the pre-write shadow contents;
  - the written columns land in the shadow;
  - the written columns' col_loaded bits end at 1 (the write wins over the commit clear).
- Output handshake: out_valid && out_ready with no accepted commit gives out_valid <= 0. frame_out keeps its value (it is not cleared).
- Consume and accepted commit in the same cycle: out_valid stays 1 and frame_out takes the new frame. This gives full throughput.
- Latency: a column written in cycle N can be committed in cycle N+1. The committed frame appears on frame_out in the cycle after the commit.
- Output-state FSM:
  - EMPTY (out_valid=0): accepted commit -> FULL.
  - FULL (out_valid=1):
    - out_ready with no commit -> EMPTY;
    - out_ready with an accepted commit -> FULL with the new frame;
    - no out_ready -> FULL, holding the frame and blocking commit.
- Rotation index: uses (c+r) mod COLS, computed with wrap. Row 0 is never rotated. For ROWS > COLS, rows rotate by r mod COLS.
- No arithmetic on data. Word width is preserved bit-exactly.

Decomposition:
- state_frame_pkg holds:
  - default WORD_W/ROWS/COLS localparams;
  - function word_lsb(r,c) = (r*COLS+c)*WORD_W;
  - function rot_src_col(r,c) = (c+r) % COLS.
- Sub-module frame_row_rotator: purely combinational, parametrised like the top level.
  - Inputs: flat frame in, rot_en.
  - Output: flat frame, rotated or passed through.
  - Instantiated once, between the shadow bank and frame_out.

Test Plan:
- Reset: drive rst=1 with wr_en=1, mask=4'hF -> after release, frame_out=0, out_valid=0, frame_complete=0, commit_ready=0.
- Load and plain commit: write word(r,c) = 32'h100*r+c with mask=4'b0001, then 4'b1110; commit with rot_en=0 -> out_valid=1, frame_out word(2,3)=32'h203, col_loaded cleared.
- Rotated commit: same data, rot_en=1 -> frame_out word(1,0)=32'h101, word(1,3)=32'h100, word(3,0)=32'h303, word(0,2)=32'h002.
- Backpressure: out_valid=1, out_ready=0, frame complete, commit held 5 cycles -> commit_ready=0 and frame_out unchanged throughout. Raise out_ready -> new frame accepted in that cycle and out_valid stays 1.
- Simultaneous write and commit: commit with mask=4'b0100 writing 32'hDEAD_BEEF to every row -> committed column 2 holds the old values, shadow column 2 = DEADBEEF, col_loaded=4'b0100, frame_complete=0.
- Incomplete frame: write masks 4'b0011 only, assert commit -> ignored, out_valid stays 0. Assert rst mid-load -> col_loaded=0.

Source files
------------

// File: rtl/state_frame_regfile_pkg.sv
// Shared sizing defaults, output-stage state encoding and frame indexing helpers
// for the cipher-state frame register file.
package state_frame_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Bit offset of word (r,c) inside a flattened row-major frame.
    function automatic int word_lsb(input int r, input int c,
                                    input int cols = DEF_COLS,
                                    input int word_w = DEF_WORD_W);
        return (r * cols + c) * word_w;
    endfunction

    // Source column for destination (r,c) under a left rotation by r.
    function automatic int rot_src_col(input int r, input int c,
                                       input int cols = DEF_COLS);
        return (c + r) % cols;
    endfunction

endpackage

// File: rtl/state_frame_regfile_rotator.sv
// Combinational per-row rotation of a flattened frame: row r is rotated left
// by r columns when rot_en is set, otherwise the frame passes through.
module frame_row_rotator
    import state_frame_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic [ROWS*COLS*WORD_W-1:0] frame_in,
    input  logic                        rot_en,
    output logic [ROWS*COLS*WORD_W-1:0] frame_out
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                localparam int DST = word_lsb(gi, gj, COLS, WORD_W);
                localparam int SRC = word_lsb(gi, rot_src_col(gi, gj, COLS), COLS, WORD_W);
                assign frame_out[DST +: WORD_W] = rot_en ? frame_in[SRC +: WORD_W]
                                                         : frame_in[DST +: WORD_W];
            end
        end
    endgenerate

endmodule

// File: rtl/state_frame_regfile.sv
// Column-loaded shadow bank committed as a whole frame (optionally row-rotated)
// into a valid/ready output register.
module state_frame_regfile
    import state_frame_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [COLS-1:0]             wr_col_mask,
    input  logic [ROWS*COLS*WORD_W-1:0] frame_in,
    input  logic                        commit,
    input  logic                        rot_en,
    output logic                        commit_ready,
    output logic                        frame_complete,
    output logic [ROWS*COLS*WORD_W-1:0] frame_out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int FRAME_W = ROWS * COLS * WORD_W;

    logic [FRAME_W-1:0] shadow_reg;
    logic [FRAME_W-1:0] shadow_next;
    logic [COLS-1:0]    col_loaded_reg;
    logic [COLS-1:0]    col_loaded_next;
    logic [FRAME_W-1:0] frame_out_reg;
    logic [FRAME_W-1:0] rotated;
    out_state_t         state_reg;
    out_state_t         state_next;
    logic               commit_accept;

    assign frame_complete = &col_loaded_reg;
    assign out_valid      = (state_reg == OUT_FULL);
    assign commit_ready   = frame_complete && (!out_valid || out_ready);
    assign commit_accept  = commit && commit_ready;
    assign frame_out      = frame_out_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            for (gj = 0; gj < ROWS; gj++) begin : g_row
                localparam int LSB = word_lsb(gj, gi, COLS, WORD_W);
                assign shadow_next[LSB +: WORD_W] = (wr_en && wr_col_mask[gi])
                                                    ? frame_in[LSB +: WORD_W]
                                                    : shadow_reg[LSB +: WORD_W];
            end
        end
    endgenerate

    // Commit clears the loaded flags, but a same-cycle write re-marks its columns.
    always_comb begin
        col_loaded_next = commit_accept ? '0 : col_loaded_reg;
        if (wr_en) begin
            col_loaded_next = col_loaded_next | wr_col_mask;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OUT_EMPTY: if (commit_accept) state_next = OUT_FULL;
            OUT_FULL: begin
                if (commit_accept)  state_next = OUT_FULL;
                else if (out_ready) state_next = OUT_EMPTY;
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    // Rotation reads the pre-write shadow, so a same-cycle load never leaks in.
    frame_row_rotator #(
        .WORD_W (WORD_W),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) u_rotator (
        .frame_in  (shadow_reg),
        .rot_en    (rot_en),
        .frame_out (rotated)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg     <= '0;
            col_loaded_reg <= '0;
            frame_out_reg  <= '0;
            state_reg      <= OUT_EMPTY;
        end else begin
            shadow_reg     <= shadow_next;
            col_loaded_reg <= col_loaded_next;
            state_reg      <= state_next;
            if (commit_accept) begin
                frame_out_reg <= rotated;
            end
        end
    end

endmodule
